// File: rtl/pmem_arbiter.sv
// pmem_arbiter: arbitrates victim-cache writebacks and L2 line fills onto a
// single 128-bit physical-memory port.
// Optional feature macro: PMEM_RAW_FWD_EN (forward a pending writeback line
// straight to an L2 fill of the same address instead of reading memory).
module pmem_arbiter #(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         VC_write,
  input  logic [11:0]  wb_address,
  input  logic [127:0] wb_data,
  output logic         mem_ack,
  input  logic         L2_pmem_read,
  input  logic [11:0]  L2_pmem_address,
  output logic         L2_pmem_resp,
  output logic [127:0] L2_pmem_rdata,
  output logic         L2toPmem_busy,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WR_ACK,
    RD_ACK
  } state_t;

  localparam logic [1:0] LP_STARVE_MAX = 2'(STARVE_MAX);

  state_t       r_state;
  state_t       w_state_nx;
  logic [1:0]   r_starve;
  logic [11:0]  r_line_addr;
  logic [127:0] r_wdata;
  logic [127:0] r_rdata;
  logic         w_grant_wr;
  logic         w_grant_rd;
  logic         w_fwd;
  logic         w_addr_match;
  logic         w_starved;
`ifdef PMEM_RAW_FWD_EN
  logic         r_fwd_pend;
`endif

  // Every output is decoded from state or taken from a latch: no request
  // input reaches the memory port combinationally.
  assign pmem_read     = (r_state == RD);
  assign pmem_write    = (r_state == WR);
  assign mem_ack       = (r_state == WR_ACK);
  assign L2_pmem_resp  = (r_state == RD_ACK);
  assign L2toPmem_busy = (r_state == RD) || (r_state == RD_ACK);
  assign pmem_address  = {r_line_addr, 4'b0000};
  assign pmem_wdata    = r_wdata;
  assign L2_pmem_rdata = r_rdata;

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    w_fwd        = 1'b0;
    w_addr_match = (L2_pmem_address == wb_address);
    w_starved    = (r_starve == LP_STARVE_MAX);
    if (r_state == IDLE) begin
      if (L2_pmem_read && VC_write) begin
`ifdef PMEM_RAW_FWD_EN
        // A write left pending by a forward goes next regardless of the counter.
        if (r_fwd_pend || w_starved) begin
          w_grant_wr = 1'b1;
        end else if (w_addr_match) begin
          w_fwd = 1'b1;
        end else begin
          w_grant_rd = 1'b1;
        end
`else
        // Same-line conflict: write first so the fill reads the new line.
        if (w_addr_match || w_starved) begin
          w_grant_wr = 1'b1;
        end else begin
          w_grant_rd = 1'b1;
        end
`endif
      end else if (L2_pmem_read) begin
        w_grant_rd = 1'b1;
      end else if (VC_write) begin
        w_grant_wr = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_wr) begin
          w_state_nx = WR;
        end else if (w_grant_rd) begin
          w_state_nx = RD;
        end else if (w_fwd) begin
          w_state_nx = RD_ACK;
        end
      end
      WR:      if (pmem_resp) w_state_nx = WR_ACK;
      RD:      if (pmem_resp) w_state_nx = RD_ACK;
      WR_ACK:  w_state_nx = IDLE;
      RD_ACK:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Address/data latches captured at grant, fill data captured on response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_line_addr <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_grant_wr) begin
        r_line_addr <= wb_address;
        r_wdata     <= wb_data;
      end else if (w_grant_rd) begin
        r_line_addr <= L2_pmem_address;
      end
      if (w_fwd) begin
        r_rdata <= wb_data;
      end else if ((r_state == RD) && pmem_resp) begin
        r_rdata <= pmem_rdata;
      end
    end
  end

  // Starve counter: reads granted while a writeback waits, saturating.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (!VC_write || w_grant_wr) begin
        r_starve <= '0;
      end else if ((w_grant_rd || w_fwd) && !w_starved) begin
        r_starve <= r_starve + 2'd1;
      end
    end
  end

`ifdef PMEM_RAW_FWD_EN
  // Remembers that a forward bypassed the writeback; cleared at the next IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fwd_pend <= 1'b0;
    end else if (w_fwd) begin
      r_fwd_pend <= 1'b1;
    end else if (r_state == IDLE) begin
      r_fwd_pend <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios followed by a
// randomized phase checked against a transaction-level reference.
module tb_pmem_arbiter;

  localparam int unsigned SM = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         VC_write;
  logic [11:0]  wb_address;
  logic [127:0] wb_data;
  logic         mem_ack;
  logic         L2_pmem_read;
  logic [11:0]  L2_pmem_address;
  logic         L2_pmem_resp;
  logic [127:0] L2_pmem_rdata;
  logic         L2toPmem_busy;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  pmem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .VC_write       (VC_write),
    .wb_address     (wb_address),
    .wb_data        (wb_data),
    .mem_ack        (mem_ack),
    .L2_pmem_read   (L2_pmem_read),
    .L2_pmem_address(L2_pmem_address),
    .L2_pmem_resp   (L2_pmem_resp),
    .L2_pmem_rdata  (L2_pmem_rdata),
    .L2toPmem_busy  (L2toPmem_busy),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Memory model state and monitor history.
  logic [127:0] tb_mem  [logic [11:0]];
  logic [127:0] ref_mem [logic [11:0]];
  logic [11:0]  wr_list [$];
  int unsigned  mem_delay = 1;
  int unsigned  cur_delay = 1;
  int unsigned  scnt = 0;
  bit           rand_delay = 0;
  bit           force_resp = 0;
  bit           prev_rd = 0, prev_wr = 0, prev_resp = 0, prev_ack = 0;
  bit           rd_rise, wr_rise;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] pattern(input logic [11:0] a);
    return {8{4'hC, a}};
  endfunction

  function automatic logic [127:0] mem_get(input logic [11:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : pattern(a);
  endfunction

  function automatic logic [127:0] ref_get(input logic [11:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  // One clock: sample outputs 1 time unit after the edge, check port rules,
  // then let the memory model drive its response for this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("rd_wr_exclusive", pmem_read && pmem_write, 0);
    chk("busy_rule", L2toPmem_busy, pmem_read || L2_pmem_resp);
    chk("ack_after_wr_resp", mem_ack, prev_wr && prev_resp);
    chk("ack_one_cycle", mem_ack && prev_ack, 0);
    rd_rise   = pmem_read && !prev_rd;
    wr_rise   = pmem_write && !prev_wr;
    prev_rd   = pmem_read;
    prev_wr   = pmem_write;
    prev_ack  = mem_ack;
    if (pmem_read || pmem_write) begin
      scnt++;
      if (scnt == 1) cur_delay = rand_delay ? $urandom_range(1, 4) : mem_delay;
      if (scnt == cur_delay) begin
        pmem_resp = 1'b1;
        if (pmem_read) pmem_rdata = mem_get(pmem_address[15:4]);
        else tb_mem[pmem_address[15:4]] = pmem_wdata;
      end else begin
        pmem_resp = 1'b0;
      end
    end else begin
      scnt      = 0;
      pmem_resp = 1'b0;
    end
    if (force_resp) pmem_resp = 1'b1;
    prev_resp = pmem_resp;
  endtask

  initial begin
    int unsigned wcyc, acks, ng, k_resp;
    byte         grants [6];
    byte         first;
    bit          saw_read, l2_done, vc_done;
    logic [127:0] l2_data;
    // random-phase requester state
    bit          l2_act, vc_act;
    logic [11:0] l2_a, vc_a;
    logic [127:0] vc_d;
    int unsigned l2_wait, vc_wait, vc_reads;

    reset_n = 1'b0; VC_write = 1'b0; L2_pmem_read = 1'b0;
    wb_address = '0; wb_data = '0; L2_pmem_address = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset state
    step(); step();
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_l2_resp", L2_pmem_resp, 0);
    chk("rst_busy", L2toPmem_busy, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_l2_rdata", L2_pmem_rdata, 0);
    reset_n = 1'b1;
    step();

    // L2 fill at 0x123, 1-cycle memory
    tb_mem[12'h123] = {16{8'hA5}};
    mem_delay = 1;
    L2_pmem_read = 1'b1; L2_pmem_address = 12'h123;
    step();
    chk("t1_pmem_read", pmem_read, 1);
    chk("t1_pmem_address", pmem_address, 16'h1230);
    chk("t1_busy_rd", L2toPmem_busy, 1);
    step();
    chk("t1_l2_resp", L2_pmem_resp, 1);
    chk("t1_l2_rdata", L2_pmem_rdata, {16{8'hA5}});
    chk("t1_busy_ack", L2toPmem_busy, 1);
    chk("t1_read_dropped", pmem_read, 0);
    L2_pmem_read = 1'b0;
    step();
    chk("t1_resp_done", L2_pmem_resp, 0);
    chk("t1_busy_done", L2toPmem_busy, 0);

    // Writeback at 0xFFF, 5-cycle memory
    mem_delay = 5; wcyc = 0; acks = 0;
    VC_write = 1'b1; wb_address = 12'hFFF; wb_data = 128'h1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (pmem_write) begin
        wcyc++;
        chk("t2_pmem_address", pmem_address, 16'hFFF0);
        chk("t2_pmem_wdata", pmem_wdata, 128'h1);
      end
      if (mem_ack) begin
        acks++;
        VC_write = 1'b0;
      end
    end
    chk("t2_write_cycles", wcyc, 5);
    chk("t2_ack_pulses", acks, 1);
    chk("t2_mem_written", mem_get(12'hFFF), 128'h1);

    // Both requests held: grant order follows the starve limit
    mem_delay = 1; ng = 0;
    L2_pmem_read = 1'b1; L2_pmem_address = 12'h0A0;
    VC_write = 1'b1; wb_address = 12'h0B0; wb_data = {4{32'hDEAD_BEEF}};
    for (int k = 0; k < 80 && ng < 6; k++) begin
      step();
      if (rd_rise) begin grants[ng] = "R"; ng++; end
      else if (wr_rise) begin grants[ng] = "W"; ng++; end
    end
    chk("t3_grant_count", ng, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_grant%0d", i), grants[i], ((i % (SM + 1)) == SM) ? "W" : "R");
    L2_pmem_read = 1'b0; VC_write = 1'b0;
    repeat (4) step();

    // Same-line conflict at 0x040
    tb_mem[12'h040] = pattern(12'h040);
    first = "-"; saw_read = 0; l2_done = 0; vc_done = 0; k_resp = 0; l2_data = '0;
    L2_pmem_read = 1'b1; L2_pmem_address = 12'h040;
    VC_write = 1'b1; wb_address = 12'h040; wb_data = {4{32'h0BAD_F00D}};
    for (int k = 1; k <= 40 && !(l2_done && vc_done); k++) begin
      step();
      if (first == "-" && rd_rise) first = "R";
      if (first == "-" && wr_rise) first = "W";
      if (pmem_read && !l2_done) saw_read = 1;
      if (L2_pmem_resp) begin
        l2_data = L2_pmem_rdata; l2_done = 1; k_resp = k; L2_pmem_read = 1'b0;
      end
      if (mem_ack) begin vc_done = 1; VC_write = 1'b0; end
    end
    chk("t4_l2_done", l2_done, 1);
    chk("t4_vc_done", vc_done, 1);
    chk("t4_l2_data", l2_data, {4{32'h0BAD_F00D}});
    chk("t4_mem_line", mem_get(12'h040), {4{32'h0BAD_F00D}});
`ifdef PMEM_RAW_FWD_EN
    chk("t4_fwd_no_read", saw_read, 0);
    chk("t4_fwd_latency", k_resp, 1);
`else
    chk("t4_write_first", first, "W");
    chk("t4_read_issued", saw_read, 1);
`endif
    repeat (2) step();

    // Reset during a read with the memory response still pending
    mem_delay = 4;
    L2_pmem_read = 1'b1; L2_pmem_address = 12'h2AB;
    step(); step();
    chk("t5_in_read", pmem_read, 1);
    reset_n = 1'b0;
    step();
    chk("t5_rst_read", pmem_read, 0);
    chk("t5_rst_busy", L2toPmem_busy, 0);
    chk("t5_rst_resp", L2_pmem_resp, 0);
    chk("t5_rst_addr", pmem_address, 0);
    chk("t5_rst_rdata", L2_pmem_rdata, 0);
    reset_n = 1'b1; L2_pmem_read = 1'b0;
    force_resp = 1;
    step();
    force_resp = 0;
    step();
    chk("t5_stray_no_l2", L2_pmem_resp, 0);
    chk("t5_stray_no_ack", mem_ack, 0);
    chk("t5_stray_idle", pmem_read || pmem_write, 0);
    step();
    chk("t5_stray_no_l2_late", L2_pmem_resp, 0);
    mem_delay = 1; l2_done = 0;
    L2_pmem_read = 1'b1; L2_pmem_address = 12'h155;
    for (int k = 0; k < 10 && !l2_done; k++) begin
      step();
      if (L2_pmem_resp) begin
        l2_done = 1;
        chk("t5_after_data", L2_pmem_rdata, pattern(12'h155));
        L2_pmem_read = 1'b0;
      end
    end
    chk("t5_after_served", l2_done, 1);
    repeat (2) step();

    // Randomized traffic against a transaction-level reference
    ref_mem = tb_mem;
    rand_delay = 1;
    l2_act = 0; vc_act = 0; l2_wait = 0; vc_wait = 0; vc_reads = 0;
    l2_a = '0; vc_a = '0; vc_d = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!l2_act && $urandom_range(0, 2) == 0) begin
        do begin
          if (wr_list.size() > 0 && $urandom_range(0, 1) == 1)
            l2_a = wr_list[$urandom_range(0, wr_list.size() - 1)];
          else
            l2_a = {1'b0, 11'($urandom)};
        end while (vc_act && l2_a == vc_a);
        l2_act = 1; l2_wait = 0;
        L2_pmem_read = 1'b1; L2_pmem_address = l2_a;
      end
      if (!vc_act && $urandom_range(0, 3) == 0) begin
        do vc_a = {1'b1, 11'($urandom)}; while (l2_act && l2_a == vc_a);
        vc_d = {$urandom, $urandom, $urandom, $urandom};
        vc_act = 1; vc_wait = 0; vc_reads = 0;
        VC_write = 1'b1; wb_address = vc_a; wb_data = vc_d;
      end
      step();
      if (l2_act) begin
        l2_wait++;
        if (rd_rise) begin
          if (vc_act) vc_reads++;
          chk("rand_rd_addr", pmem_address, {l2_a, 4'h0});
        end
        if (L2_pmem_resp) begin
          chk("rand_rd_data", L2_pmem_rdata, ref_get(l2_a));
          l2_act = 0; L2_pmem_read = 1'b0;
        end else if (l2_wait > 100) begin
          chk("rand_rd_timeout", L2_pmem_resp, 1);
          l2_act = 0; L2_pmem_read = 1'b0;
        end
      end
      if (vc_act) begin
        vc_wait++;
        if (wr_rise) begin
          chk("rand_starve_bound", vc_reads <= SM, 1);
          chk("rand_wr_addr", pmem_address, {vc_a, 4'h0});
          chk("rand_wr_data", pmem_wdata, vc_d);
        end
        if (mem_ack) begin
          chk("rand_wr_landed", mem_get(vc_a), vc_d);
          ref_mem[vc_a] = vc_d;
          wr_list.push_back(vc_a);
          vc_act = 0; VC_write = 1'b0;
        end else if (vc_wait > 100) begin
          chk("rand_wr_timeout", mem_ack, 1);
          vc_act = 0; VC_write = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Memory-side responder behind the victim cache and L2.
- Accepts line writebacks from the victim cache (`VC_write`/`wb_address`/`wb_data`, answered with `mem_ack`) and line fills from L2.
- Arbitrates between the two requesters and drives the single 128-bit physical-memory port.
- Reports L2 fill activity to the victim cache on `L2toPmem_busy`.

## Interface
- `STARVE_MAX`, default 2: consecutive L2 reads granted while a VC write waits before the write is forced next.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `VC_write` in 1: victim cache writeback request, level, held until `mem_ack`.
- `wb_address` in 12: line address of the writeback.
- `wb_data` in 128: writeback line.
- `mem_ack` out 1: one-cycle writeback completion pulse.
- `L2_pmem_read` in 1: L2 fill request, level, held until `L2_pmem_resp`.
- `L2_pmem_address` in 12: line address of the fill.
- `L2_pmem_resp` out 1: one-cycle fill completion pulse.
- `L2_pmem_rdata` out 128: fill line, valid while `L2_pmem_resp` is high.
- `L2toPmem_busy` out 1: high while an L2 fill owns the memory port.
- `pmem_read` out 1: physical memory read strobe.
- `pmem_write` out 1: physical memory write strobe.
- `pmem_address` out 16: byte address, `{line_addr, 4'b0000}`.
- `pmem_wdata` out 128: write line.
- `pmem_rdata` in 128: read line.
- `pmem_resp` in 1: physical memory completion, one cycle.

## Operation
- FSM states: IDLE, WR, RD, WR_ACK, RD_ACK.
- IDLE grant rules:
  - Only `L2_pmem_read` high → RD.
  - Only `VC_write` high → WR.
  - Both high → RD, unless the starve counter equals `STARVE_MAX`, then WR.
  - Neither high → stay in IDLE.
- On grant, the address (and data for a write) is latched into internal registers. Memory outputs are driven from these latches, so requester changes after grant are ignored.
- WR: `pmem_write` = 1, `pmem_address`/`pmem_wdata` held from the latches. On `pmem_resp` → WR_ACK.
- RD: `pmem_read` = 1, `L2toPmem_busy` = 1. On `pmem_resp`, `pmem_rdata` is captured into `L2_pmem_rdata` → RD_ACK.
- WR_ACK: `mem_ack` = 1 for exactly one cycle → IDLE.
- RD_ACK: `L2_pmem_resp` = 1 and `L2toPmem_busy` = 1 for exactly one cycle → IDLE.
- Starve counter (2 bits):
  - Increments on each RD grant made while `VC_write` is high.
  - Clears on any WR grant, and whenever `VC_write` is low in IDLE.
  - Saturates at `STARVE_MAX`.
- `pmem_read` and `pmem_write` are never high together. The memory strobes are low in IDLE and in both ACK states.

## Timing
- Reset (`reset_n` low at an edge):
  - State → IDLE.
  - `mem_ack`, `L2_pmem_resp`, `L2toPmem_busy`, `pmem_read`, `pmem_write` = 0.
  - `pmem_address` = 0, `pmem_wdata` = 0, `L2_pmem_rdata` = 0, starve counter = 0.
  - An in-flight memory transaction is abandoned. No ack is issued for it.
- All outputs are registered or decoded from state only. No combinational path runs from a request input to a `pmem_*` output.
- Latency:
  - Request seen in IDLE at edge N → memory strobe high in cycle N+1.
  - `pmem_resp` at edge M → ack high in cycle M+1.
  - With a 1-cycle memory, minimum request-to-ack latency is 3 cycles.
- An ack is high for exactly one cycle. The requester must drop its request at the edge that ends the ack cycle.
- Back-to-back requests: the next grant is made in the IDLE cycle that follows the ACK state. One idle bubble is mandatory.
- A `pmem_resp` seen in IDLE or in an ACK state is ignored.

## Configuration
- `PMEM_RAW_FWD_EN` defined:
  - Applies when both requests are high in IDLE with `L2_pmem_address == wb_address`.
  - `wb_data` is latched into `L2_pmem_rdata`, then the FSM goes to RD_ACK with no memory read.
  - The pending write is then granted at the next IDLE cycle regardless of the starve counter.
- `PMEM_RAW_FWD_EN` undefined:
  - The same address match forces WR first. The L2 read is granted afterwards and returns the freshly written line from memory.
  - Read-after-writeback coherence holds either way.

## Test plan
- Reset, then `L2_pmem_read` = 1 with address 0x123, 1-cycle memory returning `128'hA5..A5`:
  - `pmem_read` high with `pmem_address` = 0x1230.
  - `L2_pmem_resp` pulses 3 cycles after the request with data A5..A5.
  - `L2toPmem_busy` is high for 2 cycles.
- `VC_write` with address 0xFFF, data `128'h1`, memory delaying `pmem_resp` 5 cycles:
  - `pmem_write` holds for 5 cycles with `pmem_address` = 0xFFF0.
  - `mem_ack` gives a single pulse.
- Both requests held continuously at different addresses, `STARVE_MAX` = 2: grant order is RD, RD, WR, then repeats.
- Both requests at address 0x040:
  - With `PMEM_RAW_FWD_EN`: `L2_pmem_resp` returns `wb_data` 1 cycle after the grant cycle, and no `pmem_read` is issued.
  - Without it: `pmem_write` happens before `pmem_read`.
- Reset asserted during RD with `pmem_resp` pending: all outputs are 0 the next cycle, a later stray `pmem_resp` produces no ack, and a new request is served normally.
